// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_responder
//  Description : Camera-side SCCB responder (slave). Oversamples SIO_C and
//                SIO_D on clk, decodes 3-phase write and 2-phase write +
//                2-phase read cycles, and presents register accesses to an
//                external 8-bit register file.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEV_ID    7-bit device ID (write byte {DEV_ID,0}, read byte {DEV_ID,1})
//    SYNC_STG  synchronizer depth on sio_c / sio_d_in (>= 2)
//  Build option
//    SCCB_ACK_EN  when defined, the 9th bit of each accepted byte is driven
//                 low (I2C-style ACK); otherwise it is never driven.
//  Ports
//    clk        in   system clock, >= 8x SIO_C frequency
//    reset_n    in   synchronous active-low reset
//    sio_c      in   SCCB clock from master
//    sio_d_in   in   SCCB data pad input
//    sio_d_oe   out  1 = pull SIO_D low, 0 = release
//    wr_stb     out  1-clk pulse: write wr_data to register wr_addr
//    wr_addr    out  write subaddress
//    wr_data    out  write data
//    rd_stb     out  1-clk pulse: request register rd_addr
//    rd_addr    out  read subaddress (last subaddress written)
//    rd_data    in   register value, valid 1 clk after rd_stb
//    busy       out  1 from START to STOP
//    id_err     out  1-clk pulse: ID byte did not match DEV_ID
// ============================================================================
module sccb_responder #(
    parameter logic [6:0] DEV_ID   = 7'h21,
    parameter int         SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sio_c,
    input  logic       sio_d_in,
    output logic       sio_d_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_stb,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       id_err
);

`ifdef SCCB_ACK_EN
    localparam logic c_ACK_EN = 1'b1;
`else
    localparam logic c_ACK_EN = 1'b0;
`endif

    localparam logic [7:0] c_WR_ID = {DEV_ID, 1'b0};
    localparam logic [7:0] c_RD_ID = {DEV_ID, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ID     = 4'd1,
        ST_ID_X   = 4'd2,
        ST_SUB    = 4'd3,
        ST_SUB_X  = 4'd4,
        ST_WDAT   = 4'd5,
        ST_WDAT_X = 4'd6,
        ST_RDAT   = 4'd7,
        ST_RDAT_X = 4'd8,
        ST_SKIP   = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge/condition detection
    // ------------------------------------------------------------------
    logic [SYNC_STG-1:0] r_sc_sync;
    logic [SYNC_STG-1:0] r_sd_sync;
    logic                r_sc_d;
    logic                r_sd_d;

    // Reset to the idle-bus level (both high) so leaving reset never
    // fabricates a START, STOP or clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sc_sync <= '1;
            r_sd_sync <= '1;
            r_sc_d    <= 1'b1;
            r_sd_d    <= 1'b1;
        end else begin
            r_sc_sync <= {r_sc_sync[SYNC_STG-2:0], sio_c};
            r_sd_sync <= {r_sd_sync[SYNC_STG-2:0], sio_d_in};
            r_sc_d    <= r_sc_sync[SYNC_STG-1];
            r_sd_d    <= r_sd_sync[SYNC_STG-1];
        end
    end

    logic w_sc;
    logic w_sd;
    logic w_sc_rise;
    logic w_sc_fall;
    logic w_start;
    logic w_stop;

    assign w_sc      = r_sc_sync[SYNC_STG-1];
    assign w_sd      = r_sd_sync[SYNC_STG-1];
    assign w_sc_rise =  w_sc & ~r_sc_d;
    assign w_sc_fall = ~w_sc &  r_sc_d;
    // Data transitions only count as START/STOP while the clock is stably high.
    assign w_start   = w_sc & r_sc_d &  r_sd_d & ~w_sd;
    assign w_stop    = w_sc & r_sc_d & ~r_sd_d &  w_sd;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic       r_is_rd;
    logic       r_oe;
    logic       r_busy;
    logic [7:0] r_rd_addr;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_wr_stb;
    logic       r_rd_stb;
    logic       r_id_err;

    state_t     w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] w_shreg_nxt;
    logic       w_is_rd_nxt;
    logic       w_oe_nxt;
    logic       w_busy_nxt;
    logic [7:0] w_rd_addr_nxt;
    logic [7:0] w_wr_addr_nxt;
    logic [7:0] w_wr_data_nxt;
    logic       w_wr_stb_nxt;
    logic       w_rd_stb_nxt;
    logic       w_id_err_nxt;
    logic [7:0] w_byte;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'd0;
            r_is_rd   <= 1'b0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_addr <= 8'd0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_id_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_is_rd   <= w_is_rd_nxt;
            r_oe      <= w_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_rd_stb  <= w_rd_stb_nxt;
            r_id_err  <= w_id_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_is_rd_nxt   = r_is_rd;
        w_oe_nxt      = r_oe;
        w_busy_nxt    = r_busy;
        w_rd_addr_nxt = r_rd_addr;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_wr_stb_nxt  = 1'b0;
        w_rd_stb_nxt  = 1'b0;
        w_id_err_nxt  = 1'b0;
        w_byte        = {r_shreg[6:0], w_sd};

        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 3'd0;
            w_shreg_nxt   = 8'd0;
            w_oe_nxt      = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ST_ID;
            w_bit_cnt_nxt = 3'd0;
            w_shreg_nxt   = 8'd0;
            w_is_rd_nxt   = 1'b0;
            w_oe_nxt      = 1'b0;
            w_busy_nxt    = 1'b1;
        end else begin
            // Drive changes happen only while the clock is low. Each X state
            // sees exactly one falling edge (the one ending bit 8), so the
            // ACK spans that fall to the fall after the 9th bit, where the
            // following state releases or drives its first data bit.
            if (w_sc_fall) begin
                case (r_state)
                    ST_ID_X, ST_SUB_X, ST_WDAT_X: w_oe_nxt = c_ACK_EN;
                    ST_RDAT: begin
                        w_oe_nxt    = ~r_shreg[7];
                        w_shreg_nxt = {r_shreg[6:0], 1'b0};
                    end
                    default: w_oe_nxt = 1'b0;
                endcase
            end

            if (w_sc_rise) begin
                case (r_state)
                    ST_ID: begin
                        w_shreg_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte == c_WR_ID) begin
                                w_state_nxt = ST_ID_X;
                                w_is_rd_nxt = 1'b0;
                            end else if (w_byte == c_RD_ID) begin
                                w_state_nxt  = ST_ID_X;
                                w_is_rd_nxt  = 1'b1;
                                w_rd_stb_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = ST_SKIP;
                                w_id_err_nxt = 1'b1;
                            end
                        end
                    end
                    ST_ID_X: begin
                        w_bit_cnt_nxt = 3'd0;
                        if (r_is_rd) begin
                            w_state_nxt = ST_RDAT;
                            w_shreg_nxt = rd_data;
                        end else begin
                            w_state_nxt = ST_SUB;
                            w_shreg_nxt = 8'd0;
                        end
                    end
                    ST_SUB: begin
                        w_shreg_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rd_addr_nxt = w_byte;
                            w_state_nxt   = ST_SUB_X;
                        end
                    end
                    ST_SUB_X: begin
                        w_bit_cnt_nxt = 3'd0;
                        w_shreg_nxt   = 8'd0;
                        w_state_nxt   = ST_WDAT;
                    end
                    ST_WDAT: begin
                        w_shreg_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = ST_WDAT_X;
                        end
                    end
                    ST_WDAT_X: begin
                        // Commit only once the 9th bit is clocked, so a STOP
                        // right after the data byte leaves the register alone.
                        w_bit_cnt_nxt = 3'd0;
                        w_wr_stb_nxt  = 1'b1;
                        w_wr_addr_nxt = r_rd_addr;
                        w_wr_data_nxt = r_shreg;
                        w_state_nxt   = ST_SKIP;
                    end
                    ST_RDAT: begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = ST_RDAT_X;
                        end
                    end
                    ST_RDAT_X: begin
                        w_bit_cnt_nxt = 3'd0;
                        w_state_nxt   = ST_SKIP;
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    assign sio_d_oe = r_oe;
    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_stb   = r_rd_stb;
    assign rd_addr  = r_rd_addr;
    assign busy     = r_busy;
    assign id_err   = r_id_err;

endmodule
`default_nettype wire
